// File: rtl/fetch_instr_buffer.sv
// rtl/fetch_instr_buffer.sv - in-order fetch tag queue between fetch control and instruction memory
module fetch_instr_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [5:0]  fetch_wfid,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_first,
    output logic        fetch_ready,
    input  logic        squash_valid,
    input  logic [5:0]  squash_wfid,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rd_data,
    output logic [38:0] buff_tag,
    output logic [31:0] buff_instr,
    output logic        buff_ack,
    output logic        err_unexpected_ack
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_alive;
    logic [DEPTH-1:0] q_first;
    logic [5:0]       q_wfid [DEPTH];
    logic [31:0]      q_pc   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic accept;
    logic pop;
    logic pop_alive;

    // Gated by rst so the ready output reads 0 throughout reset.
    assign fetch_ready = rst && (count != FULL_COUNT);
    assign accept      = fetch_valid && fetch_ready;
    assign pop         = mem_ack && (count != '0);
    // A squash landing on the entry being popped wins over its stale alive bit.
    assign pop_alive   = q_alive[rd_ptr] &&
                         !(squash_valid && (q_wfid[rd_ptr] == squash_wfid));

    always_ff @(posedge clk) begin
        if (accept) begin
            q_first[wr_ptr] <= fetch_first;
            q_wfid[wr_ptr]  <= fetch_wfid;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_valid            <= '0;
            q_alive            <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            mem_rd_en          <= 1'b0;
            mem_addr           <= '0;
            buff_tag           <= '0;
            buff_instr         <= '0;
            buff_ack           <= 1'b0;
            err_unexpected_ack <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_valid && q_valid[i] && (q_wfid[i] == squash_wfid)) begin
                    q_alive[i] <= 1'b0;
                end
            end

            buff_ack <= 1'b0;
            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
                buff_tag        <= {q_first[rd_ptr], q_wfid[rd_ptr], q_pc[rd_ptr]};
                buff_instr      <= mem_rd_data;
                buff_ack        <= pop_alive;
            end

            // Written after the squash loop so a same-cycle accept stays alive.
            mem_rd_en <= accept;
            if (accept) begin
                q_valid[wr_ptr] <= 1'b1;
                q_alive[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
                mem_addr        <= fetch_pc;
            end

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (mem_ack && (count == '0)) begin
                err_unexpected_ack <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_instr_buffer.sv
// tb/tb_fetch_instr_buffer.sv - self-checking bench for fetch_instr_buffer
module tb_fetch_instr_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [5:0]  fetch_wfid = '0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_first = 1'b0;
    logic        fetch_ready;
    logic        squash_valid = 1'b0;
    logic [5:0]  squash_wfid = '0;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rd_data = '0;
    logic [38:0] buff_tag;
    logic [31:0] buff_instr;
    logic        buff_ack;
    logic        err_unexpected_ack;

    always #5 clk = ~clk;

    fetch_instr_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_wfid(fetch_wfid), .fetch_pc(fetch_pc),
        .fetch_first(fetch_first), .fetch_ready(fetch_ready),
        .squash_valid(squash_valid), .squash_wfid(squash_wfid),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rd_data(mem_rd_data),
        .buff_tag(buff_tag), .buff_instr(buff_instr), .buff_ack(buff_ack),
        .err_unexpected_ack(err_unexpected_ack)
    );

    typedef struct {
        logic        alive;
        logic        first;
        logic [5:0]  wfid;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [38:0] ack_log[$];
    logic        e_rd_en = 1'b0, e_ack = 1'b0, e_err = 1'b0;
    logic [31:0] e_addr = '0, e_instr = '0;
    logic [38:0] e_tag = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".fetch_ready"}, 64'(fetch_ready), 64'(rst && (mq.size() != DEPTH)));
        chk({tag, ".mem_rd_en"}, 64'(mem_rd_en), 64'(e_rd_en));
        chk({tag, ".mem_addr"}, 64'(mem_addr), 64'(e_addr));
        chk({tag, ".buff_ack"}, 64'(buff_ack), 64'(e_ack));
        chk({tag, ".buff_tag"}, 64'(buff_tag), 64'(e_tag));
        chk({tag, ".buff_instr"}, 64'(buff_instr), 64'(e_instr));
        chk({tag, ".err"}, 64'(err_unexpected_ack), 64'(e_err));
    endtask

    task automatic model_reset();
        mq.delete();
        e_rd_en = 0; e_ack = 0; e_err = 0;
        e_addr = '0; e_instr = '0; e_tag = '0;
    endtask

    // Advance one clock: update the reference queue from the applied inputs, then compare.
    task automatic cycle(input string tag);
        bit   rdy, acc;
        ent_t e;
        if (!rst) begin
            model_reset();
        end else begin
            rdy = (mq.size() != DEPTH);
            acc = fetch_valid && rdy;
            if (squash_valid)
                foreach (mq[i]) if (mq[i].wfid == squash_wfid) mq[i].alive = 1'b0;
            e_ack = 1'b0;
            if (mem_ack && mq.size() == 0) e_err = 1'b1;
            if (mem_ack && mq.size() != 0) begin
                e = mq.pop_front();
                e_ack   = e.alive;
                e_tag   = {e.first, e.wfid, e.pc};
                e_instr = mem_rd_data;
            end
            e_rd_en = acc;
            if (acc) begin
                e_addr = fetch_pc;
                e.alive = 1'b1; e.first = fetch_first; e.wfid = fetch_wfid; e.pc = fetch_pc;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        if (buff_ack) ack_log.push_back(buff_tag);
    endtask

    task automatic idle();
        fetch_valid = 0; squash_valid = 0; mem_ack = 0;
    endtask

    task automatic fetch(input logic f, input logic [5:0] w, input logic [31:0] pc);
        fetch_valid = 1; fetch_first = f; fetch_wfid = w; fetch_pc = pc;
    endtask

    initial begin
        // Reset state
        cycle("rst0");
        cycle("rst1");
        rst = 1'b1;
        #1;
        chk("rst_release.fetch_ready", 64'(fetch_ready), 64'd1);

        // 1: single fetch, ack three cycles later
        fetch(1'b1, 6'd5, 32'h100);
        cycle("t1_acc");
        chk("t1.mem_rd_en", 64'(mem_rd_en), 64'd1);
        chk("t1.mem_addr", 64'(mem_addr), 64'h100);
        idle();
        cycle("t1_w1");
        cycle("t1_w2");
        mem_ack = 1; mem_rd_data = 32'hBF810000;
        cycle("t1_ack");
        chk("t1.buff_ack", 64'(buff_ack), 64'd1);
        chk("t1.buff_tag", 64'(buff_tag), 64'({1'b1, 6'd5, 32'h100}));
        chk("t1.buff_instr", 64'(buff_instr), 64'hBF810000);
        idle();
        cycle("t1_post");
        chk("t1.ack_pulse", 64'(buff_ack), 64'd0);

        // 2: five back-to-back fetches into a depth-4 queue
        for (int i = 0; i < 5; i++) begin
            fetch(1'b0, 6'd1, 32'h200 + 32'(4 * i));
            cycle("t2_fill");
            if (i == 3) chk("t2.full_ready", 64'(fetch_ready), 64'd0);
        end
        mem_ack = 1; mem_rd_data = $urandom;
        cycle("t2_pop");
        chk("t2.ready_after_pop", 64'(fetch_ready), 64'd1);
        chk("t2.held_not_issued", 64'(mem_rd_en), 64'd0);
        mem_ack = 0;
        cycle("t2_acc5");
        chk("t2.fifth_addr", 64'(mem_addr), 64'h210);
        idle();
        repeat (4) begin
            mem_ack = 1; mem_rd_data = $urandom;
            cycle("t2_drain");
        end
        idle();

        // 3: accept and pop together at count 2, wrapping over 10 requests
        ack_log.delete();
        for (int i = 0; i < 10; i++) begin
            fetch(1'b0, 6'(i), 32'h1000 + 32'(i));
            mem_ack = (i >= 2); mem_rd_data = $urandom;
            cycle("t3_stream");
            chk("t3.ready", 64'(fetch_ready), 64'd1);
        end
        fetch_valid = 0;
        repeat (2) begin
            mem_ack = 1; mem_rd_data = $urandom;
            cycle("t3_drain");
        end
        idle();
        chk("t3.ack_count", 64'(ack_log.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            if (i < ack_log.size())
                chk("t3.order", 64'(ack_log[i]), 64'({1'b0, 6'(i), 32'h1000 + 32'(i)}));

        // 4: squash wfid 3 with a same-cycle wfid-3 accept
        ack_log.delete();
        fetch(1'b0, 6'd3, 32'h300); cycle("t4_a");
        fetch(1'b0, 6'd7, 32'h304); cycle("t4_b");
        fetch(1'b0, 6'd3, 32'h308); cycle("t4_c");
        fetch(1'b1, 6'd3, 32'h30C); squash_valid = 1; squash_wfid = 6'd3;
        cycle("t4_squash");
        idle();
        repeat (4) begin
            mem_ack = 1; mem_rd_data = $urandom;
            cycle("t4_ret");
        end
        idle();
        chk("t4.ack_count", 64'(ack_log.size()), 64'd2);
        if (ack_log.size() == 2) begin
            chk("t4.survivor", 64'(ack_log[0]), 64'({1'b0, 6'd7, 32'h304}));
            chk("t4.same_cycle", 64'(ack_log[1]), 64'({1'b1, 6'd3, 32'h30C}));
        end

        // Randomized traffic with squashes, kept off empty acks until the error test
        for (int n = 0; n < 400; n++) begin
            fetch_valid  = 1'($urandom_range(0, 1));
            fetch_first  = 1'($urandom_range(0, 1));
            fetch_wfid   = 6'($urandom_range(0, 3));
            fetch_pc     = $urandom;
            squash_valid = ($urandom_range(0, 7) == 0);
            squash_wfid  = 6'($urandom_range(0, 3));
            mem_ack      = (mq.size() != 0) && ($urandom_range(0, 1) == 1);
            mem_rd_data  = $urandom;
            cycle("rand");
        end
        idle();
        while (mq.size() != 0) begin
            mem_ack = 1; mem_rd_data = $urandom;
            cycle("rand_drain");
        end
        idle();

        // 5: ack with an empty queue
        mem_ack = 1; mem_rd_data = 32'hDEAD;
        cycle("t5_bad");
        chk("t5.no_ack", 64'(buff_ack), 64'd0);
        chk("t5.err", 64'(err_unexpected_ack), 64'd1);
        idle();
        repeat (3) cycle("t5_hold");
        chk("t5.err_sticky", 64'(err_unexpected_ack), 64'd1);

        // 6: asynchronous reset with three entries outstanding
        for (int i = 0; i < 3; i++) begin
            fetch(1'b0, 6'd9, 32'h400 + 32'(i));
            cycle("t6_fill");
        end
        idle();
        #2 rst = 1'b0;
        #1;
        chk("t6.fetch_ready", 64'(fetch_ready), 64'd0);
        chk("t6.mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("t6.mem_addr", 64'(mem_addr), 64'd0);
        chk("t6.buff_tag", 64'(buff_tag), 64'd0);
        chk("t6.buff_instr", 64'(buff_instr), 64'd0);
        chk("t6.buff_ack", 64'(buff_ack), 64'd0);
        chk("t6.err", 64'(err_unexpected_ack), 64'd0);
        cycle("t6_inrst");
        rst = 1'b1;
        #1;
        chk("t6.ready_after", 64'(fetch_ready), 64'd1);
        fetch(1'b1, 6'd2, 32'h500);
        cycle("t6_acc");
        idle();
        mem_ack = 1; mem_rd_data = 32'h12345678;
        cycle("t6_ack");
        chk("t6.new_ack", 64'(buff_ack), 64'd1);
        chk("t6.new_tag", 64'(buff_tag), 64'({1'b1, 6'd2, 32'h500}));
        idle();
        cycle("t6_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_instr_buffer.md
Name: fetch_instr_buffer

Overview:
- Sits between the fetch controller and instruction memory, directly upstream of the fetch-to-wavepool pipeline flops.
- Accepts fetch requests carrying wavefront id, PC and a first-fetch flag, and issues them to instruction memory.
- Keeps an in-order queue of outstanding request tags. On each memory return it pairs the instruction with its tag and presents the result as a one-cycle buff_tag/buff_instr/buff_ack pulse.
- Supports squashing in-flight fetches of a wavefront. Their returns are consumed but not acknowledged.

Parameters:
- DEPTH, 4, maximum outstanding memory requests; must be a power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetch_valid  input  1  fetch request present.
- fetch_wfid  input  6  wavefront id of request.
- fetch_pc  input  32  instruction address.
- fetch_first  input  1  first fetch of this wavefront.
- fetch_ready  output  1  request accepted this cycle when high with fetch_valid.
- squash_valid  input  1  discard all outstanding fetches of squash_wfid.
- squash_wfid  input  6  wavefront to squash.
- mem_rd_en  output  1  one-cycle memory read strobe.
- mem_addr  output  32  memory read address.
- mem_ack  input  1  read data valid; returns are in request order.
- mem_rd_data  input  32  returned instruction word.
- buff_tag  output  39  {first, wfid[5:0], pc[31:0]} of the returned instruction.
- buff_instr  output  32  returned instruction.
- buff_ack  output  1  one-cycle pulse: buff_tag and buff_instr valid.
- err_unexpected_ack  output  1  sticky: mem_ack seen while queue empty.

Behaviour:
Reset
- While rst is low, all outputs are 0: fetch_ready, mem_rd_en, mem_addr, buff_tag, buff_instr, buff_ack and err_unexpected_ack.
- Pointers and count reset to 0. All entry valid and alive bits reset to 0.
- Reset mid-operation drops every outstanding entry. Instruction memory is reset by the same rst, so no stale returns follow.

Queue
- Circular queue of DEPTH entries. Each entry holds {alive, first, wfid, pc}.
- count is 0..DEPTH.
- fetch_ready = (count != DEPTH), combinational from registered count. It does not depend on a pop in the same cycle.

Accept
- Accept when fetch_valid && fetch_ready.
- Write the entry at wr_ptr with alive=1, then increment wr_ptr, wrapping at DEPTH.
- Next cycle: mem_rd_en=1 and mem_addr=fetch_pc. Accept-to-memory latency is 1 cycle.
- mem_rd_en is 0 in every cycle that does not follow an accept. mem_addr holds its last value.
- Back-to-back accepts give back-to-back mem_rd_en.

Return
- On mem_ack with count != 0: pop the entry at rd_ptr and increment rd_ptr, wrapping.
- Next cycle: buff_tag = {first, wfid, pc} of the popped entry and buff_instr = mem_rd_data.
- buff_ack = 1 for that cycle only if the popped entry is alive. Return-to-ack latency is 1 cycle.
- buff_tag and buff_instr hold their values when buff_ack is 0.

Count
- Accept and pop in the same cycle: count unchanged.
- Full queue with pop: fetch_ready stays 0 this cycle and rises next cycle.
- mem_ack with count == 0: ignored; set err_unexpected_ack, which stays 1 until reset.

Squash
- squash_valid clears alive on every valid entry whose wfid equals squash_wfid. Squashed entries still occupy space until their return pops them.
- A request accepted in the same cycle as the squash is not squashed, even with matching wfid.
- A pop in the same cycle as a matching squash is suppressed: buff_ack=0.

Test Plan:
1. Single fetch {first=1, wfid=5, pc=0x100}, mem_ack 3 cycles later with data 0xBF810000 -> mem_rd_en one cycle after accept with mem_addr=0x100; buff_ack one cycle after mem_ack with buff_tag={1,6'd5,32'h100} and buff_instr=0xBF810000.
2. Five back-to-back fetches with DEPTH=4 and no acks -> fetch_ready=0 after the 4th accept; the 5th request is held. Then one mem_ack -> fetch_ready=1 the next cycle and the 5th request is accepted.
3. Simultaneous accept and mem_ack at count=2 -> count stays 2; wrap-around exercised over 10 requests; returns come out in order with matching tags.
4. Three outstanding fetches for wfids {3, 7, 3}, then squash_wfid=3, then three acks -> exactly one buff_ack, carrying wfid 7. A fetch for wfid 3 accepted in the squash cycle is later acknowledged.
5. mem_ack with empty queue -> no buff_ack; err_unexpected_ack=1 and it remains high.
6. Assert rst low with 3 entries outstanding -> all outputs 0 immediately. After release, fetch_ready=1, count=0, and a new fetch completes normally.
